// File: rtl/fx2_rx_reader.sv
// Cypress FX2 slave-FIFO reader: drains an OUT endpoint into a small FIFO with valid/ready output.
// Optional feature: define FX2_RX_WORD_COUNT_EN to add the 32-bit rx_word_count output.
module fx2_rx_reader #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [1:0]  RX_ADDR = 2'b00
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        fx2_empty_b,
  input  logic [15:0] fx2_fd_in,
  output logic        fx2_sloe_b,
  output logic        fx2_slrd_b,
  output logic [1:0]  fx2_fifo_addr,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy
`ifdef FX2_RX_WORD_COUNT_EN
  ,
  output logic [31:0] rx_word_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OE,
    S_READ,
    S_RELEASE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_room;
  logic          w_can_read;
  logic          w_push;
  logic          w_pop;

  // Two free slots are required so a strobe issued this cycle always has a home.
  assign w_room     = (r_count <= (AW + 1)'(DEPTH - 2));
  assign w_can_read = rx_en && fx2_empty_b && w_room;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    fx2_sloe_b  = 1'b1;
    fx2_slrd_b  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_can_read) w_state_nxt = S_OE;
      end
      S_OE: begin
        fx2_sloe_b  = 1'b0;
        w_state_nxt = S_READ;
      end
      S_READ: begin
        fx2_sloe_b = 1'b0;
        fx2_slrd_b = !w_can_read;
        if (!w_can_read) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Keep the bus quiet while reset is held, even before the state register clears.
    if (reset) begin
      fx2_sloe_b = 1'b1;
      fx2_slrd_b = 1'b1;
    end
  end

  assign w_push        = !fx2_slrd_b && fx2_empty_b;
  assign w_pop         = rx_valid && rx_ready;
  assign rx_valid      = (r_count != '0);
  assign rx_data       = rx_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign busy          = (r_state != S_IDLE);
  assign fx2_fifo_addr = RX_ADDR;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; r_count alone decides which entries are live.
  always_ff @(posedge ifclk) begin
    if (w_push) r_mem[r_wr_ptr] <= fx2_fd_in;
  end

`ifdef FX2_RX_WORD_COUNT_EN
  logic [31:0] r_word_count;

  always_ff @(posedge ifclk) begin
    if (reset)       r_word_count <= '0;
    else if (w_push) r_word_count <= r_word_count + 32'd1;
  end

  assign rx_word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fx2_rx_reader.sv
// Directed bench for fx2_rx_reader: an FX2 FIFO emulator, a queue model of the buffer and literal checks.
// Build with FX2_RX_WORD_COUNT_EN defined to also check rx_word_count.
module tb_fx2_rx_reader;

  localparam int         DEPTH   = 4;
  localparam logic [1:0] RX_ADDR = 2'b00;

  logic        ifclk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_en = 1'b0;
  logic        rx_ready = 1'b0;
  logic        fx2_empty_b;
  logic [15:0] fx2_fd_in;
  logic        fx2_sloe_b;
  logic        fx2_slrd_b;
  logic [1:0]  fx2_fifo_addr;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
`ifdef FX2_RX_WORD_COUNT_EN
  logic [31:0] rx_word_count;
`endif

  always #5 ifclk = ~ifclk;

  // FX2 endpoint emulator: words [fx2_rd, fx2_total) are waiting in the host FIFO.
  logic [15:0] fx2_words [64];
  int          fx2_total = 0;
  int          fx2_rd    = 0;
  assign fx2_empty_b = (fx2_rd < fx2_total);
  assign fx2_fd_in   = fx2_words[fx2_rd[5:0]];

  fx2_rx_reader #(.DEPTH(DEPTH), .RX_ADDR(RX_ADDR)) dut (
    .ifclk         (ifclk),
    .reset         (reset),
    .rx_en         (rx_en),
    .fx2_empty_b   (fx2_empty_b),
    .fx2_fd_in     (fx2_fd_in),
    .fx2_sloe_b    (fx2_sloe_b),
    .fx2_slrd_b    (fx2_slrd_b),
    .fx2_fifo_addr (fx2_fifo_addr),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .busy          (busy)
`ifdef FX2_RX_WORD_COUNT_EN
    ,
    .rx_word_count (rx_word_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Buffer model: words accepted by the block and not yet handed to the consumer.
  logic [15:0] model_q [$];
  int          model_cnt = 0;
  logic [15:0] dlv_w [$];
  int          dlv_c [$];
  int          cycle      = 0;
  int          oe_events  = 0;
  logic        prev_sloe  = 1'b1;

  int          log_base = 0;
  logic        log_sloe  [32];
  logic        log_slrd  [32];
  logic        log_busy  [32];
  logic        log_valid [32];
  logic [15:0] log_data  [32];
  logic        obs_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
  endtask

  // One clock: compare against the model at the falling edge, then apply the edge's effects.
  task automatic tick();
    logic        push, pop, rst_s;
    logic [15:0] w, d;
    int          k;
    @(negedge ifclk);
    cycle++;
    k = cycle - log_base;
    if (k >= 1 && k < 32) begin
      log_sloe[k]  = fx2_sloe_b;
      log_slrd[k]  = fx2_slrd_b;
      log_busy[k]  = busy;
      log_valid[k] = rx_valid;
      log_data[k]  = rx_data;
    end
    obs_busy = busy;
    check("fifo_addr", 32'(fx2_fifo_addr), 32'(RX_ADDR));
    check("rx_valid", 32'(rx_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("rx_data", 32'(rx_data), 32'(model_q[0]));
    if (!fx2_sloe_b) check("busy_while_bus_owned", 32'(busy), 32'd1);
    if (!fx2_sloe_b && prev_sloe) begin
      oe_events++;
      check("oe_turnaround_no_strobe", 32'(fx2_slrd_b), 32'd1);
    end else if (!fx2_sloe_b) begin
      check("read_strobe_rule", 32'(fx2_slrd_b),
            32'(!(rx_en && fx2_empty_b && !reset && model_q.size() <= DEPTH - 2)));
    end else begin
      check("no_strobe_without_oe", 32'(fx2_slrd_b), 32'd1);
    end
`ifdef FX2_RX_WORD_COUNT_EN
    check("word_count", rx_word_count, 32'(model_cnt));
`endif
    push      = !fx2_slrd_b && fx2_empty_b;
    w         = fx2_fd_in;
    pop       = rx_valid && rx_ready;
    d         = rx_data;
    rst_s     = reset;
    prev_sloe = fx2_sloe_b;
    @(posedge ifclk);
    #1;
    if (rst_s) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      if (pop && model_q.size() != 0) begin
        void'(model_q.pop_front());
        dlv_w.push_back(d);
        dlv_c.push_back(cycle);
      end
      if (push) begin
        model_q.push_back(w);
        model_cnt++;
        check("no_overflow", 32'(model_q.size() <= DEPTH), 32'd1);
      end
    end
    if (push) fx2_rd++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) fx2_words[(fx2_total + i) % 64] = base + 16'(i);
    fx2_total += n;
  endtask

  task automatic wait_delivered(input int target, input int budget);
    int b;
    b = budget;
    while (dlv_w.size() < target && b > 0) begin
      tick();
      b--;
    end
    check("delivery_within_budget", 32'(dlv_w.size()), 32'(target));
  endtask

  task automatic check_words(input int start, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      check("word_present", 32'(dlv_w.size() > start + i), 32'd1);
      if (dlv_w.size() > start + i) check("word_order", 32'(dlv_w[start + i]), 32'(base + 16'(i)));
    end
  endtask

  initial begin
    int d0, rd0, oe0;
    @(posedge ifclk);
    #1;

    // Reset state
    tick();
    check("rst_sloe_b", 32'(fx2_sloe_b), 32'd1);
    check("rst_slrd_b", 32'(fx2_slrd_b), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef FX2_RX_WORD_COUNT_EN
    check("rst_word_count", rx_word_count, 32'd0);
`endif
    tick();
    reset = 1'b0;

    // Eight-word burst with a ready consumer
    d0 = dlv_w.size(); oe0 = oe_events; log_base = cycle;
    load(16'h1000, 8);
    rx_en = 1'b1; rx_ready = 1'b1;
    run(13);
    check("b1_idle_first", 32'({log_sloe[1], log_busy[1]}), 32'b10);
    check("b1_oe_cycle", 32'({log_sloe[2], log_slrd[2]}), 32'b01);
    check("b1_first_strobe", 32'(log_slrd[3]), 32'd0);
    check("b1_first_word", 32'({log_valid[4], log_data[4]}), 32'h1_1000);
    check("b1_last_word", 32'({log_valid[11], log_data[11]}), 32'h1_1007);
    check("b1_release", 32'({log_sloe[12], log_busy[12], log_valid[12]}), 32'b110);
    check("b1_back_idle", 32'(log_busy[13]), 32'd0);
    check("b1_one_oe", 32'(oe_events - oe0), 32'd1);
    check_words(d0, 16'h1000, 8);
    for (int i = 0; i < 8; i++)
      if (dlv_w.size() > d0 + i) check("b1_no_gap", 32'(dlv_c[d0 + i] - dlv_c[d0]), 32'(i));

    // Stalled consumer: reads stop at DEPTH-1 words, then all ten drain in order
    d0 = dlv_w.size(); rd0 = fx2_rd; log_base = cycle;
    rx_ready = 1'b0;
    load(16'h2000, 10);
    run(10);
    check("b2_stop_fill", 32'(fx2_rd - rd0), 32'(DEPTH - 1));
    check("b2_release", 32'({log_sloe[7], log_busy[7]}), 32'b11);
    check("b2_parked", 32'({log_slrd[10], log_busy[10]}), 32'b10);
    rx_ready = 1'b1;
    wait_delivered(d0 + 10, 200);
    check_words(d0, 16'h2000, 10);
    run(4);
    check("b2_idle_after", 32'(obs_busy), 32'd0);

    // FIFO runs dry after three words, then refills
    d0 = dlv_w.size(); rd0 = fx2_rd; oe0 = oe_events; log_base = cycle;
    load(16'h3000, 3);
    run(8);
    check("b3_three_read", 32'(fx2_rd - rd0), 32'd3);
    check("b3_release", 32'({log_sloe[7], log_busy[7]}), 32'b11);
    check("b3_idle", 32'(log_busy[8]), 32'd0);
    check("b3_one_oe", 32'(oe_events - oe0), 32'd1);
    log_base = cycle;
    load(16'h3100, 2);
    run(8);
    check("b3_new_oe", 32'({log_sloe[2], log_slrd[2]}), 32'b01);
    check("b3_two_oe", 32'(oe_events - oe0), 32'd2);
    check_words(d0, 16'h3000, 3);
    check_words(d0 + 3, 16'h3100, 2);

    // rx_en dropped mid-burst
    d0 = dlv_w.size(); rd0 = fx2_rd; log_base = cycle;
    load(16'h4000, 8);
    run(5);
    rx_en = 1'b0;
    run(4);
    check("b4_words_before_drop", 32'(fx2_rd - rd0), 32'd3);
    check("b4_bus_released", 32'(log_sloe[7]), 32'd1);
    check("b4_idle", 32'(log_busy[8]), 32'd0);
    rx_en = 1'b1;
    wait_delivered(d0 + 8, 200);
    check_words(d0, 16'h4000, 8);
    run(4);

    // Reset pulse during READ with two words buffered
    d0 = dlv_w.size(); rd0 = fx2_rd; log_base = cycle;
    rx_ready = 1'b0;
    load(16'h5000, 6);
    run(4);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(1);
    check("b5_two_taken", 32'(fx2_rd - rd0), 32'd2);
    check("b5_reset_quiet", 32'({log_valid[6], log_slrd[6], log_sloe[6], log_busy[6]}), 32'b0110);
`ifdef FX2_RX_WORD_COUNT_EN
    check("b5_count_cleared", rx_word_count, 32'd0);
`endif
    rx_ready = 1'b1;
    wait_delivered(d0 + 4, 200);
    check_words(d0, 16'h5002, 4);
    run(4);
    check("final_idle", 32'(obs_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
